// File: rtl/wb_burst_ctrl.sv
// ---------------------------------------------------------------------------
// wb_burst_ctrl
//
// Wishbone slave front-end for the burst address incrementer. It accepts
// classic, linear-burst and wrap-burst cycles, captures the start address,
// CTI, BTE and WE, pulses init_o to load the incrementer, strobes inc_o once
// per acknowledged beat, and paces wb_ack_o with mem_rdy_i. When the
// incrementer reports the line exhausted (done_i) after at least one beat and
// the master is still requesting, the block reloads the incrementer from the
// master's current address.
//
// Optional feature: define WB_BURST_TIMEOUT_EN to enable the BURST stall
// timeout (TIMEOUT_CYC stalled cycles, then wb_err_o for one cycle and return
// to IDLE). Without the macro wb_err_o is tied low and BURST waits forever.
//
// Handshake: a beat is offered when wb_cyc_i & wb_stb_i are high (req); it
// completes in the cycle wb_ack_o is high, which requires the BURST state,
// mem_rdy_i high and no pending re-initialisation. The master must hold
// address/CTI/BTE/WE stable while req is high and ack is low.
//
// Parameters:
//   TIMEOUT_CYC  stall cycles in BURST before wb_err_o (1..255)
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i    Wishbone cycle / strobe
//   wb_we_i               Wishbone write enable
//   wb_adr_i[3:0]         word address within the 16-word line
//   wb_cti_i[2:0]         cycle type (000 classic, 010 incr, 111 end)
//   wb_bte_i[1:0]         burst type (00 linear, 01 wrap4, 10 wrap8)
//   wb_ack_o, wb_err_o    transfer acknowledge / timeout error
//   mem_rdy_i             memory can complete a beat this cycle
//   done_i                line exhausted, from the incrementer
//   adr_o, cti_o, bte_o   captured burst parameters to the incrementer
//   we_o                  captured write enable to memory
//   init_o, inc_o         incrementer load pulse / advance strobe
// ---------------------------------------------------------------------------
module wb_burst_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [3:0] wb_adr_i,
  input  logic [2:0] wb_cti_i,
  input  logic [1:0] wb_bte_i,
  output logic       wb_ack_o,
  output logic       wb_err_o,
  input  logic       mem_rdy_i,
  input  logic       done_i,
  output logic [3:0] adr_o,
  output logic [2:0] cti_o,
  output logic [1:0] bte_o,
  output logic       we_o,
  output logic       init_o,
  output logic       inc_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_WAIT  = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       beat_seen_q, beat_seen_d;
  logic [3:0] adr_q, adr_d;
  logic [2:0] cti_q, cti_d;
  logic [1:0] bte_q, bte_d;
  logic       we_q, we_d;

  logic req;
  logic reinit;
  logic ack;
  logic err;
  logic cti_end;
  logic load;

  assign req     = wb_cyc_i & wb_stb_i;
  // done_i is only meaningful once this line has produced a beat; right after
  // INIT the incrementer may still show the previous line's flag.
  assign reinit  = done_i & beat_seen_q;
  assign ack     = (state_q == S_BURST) & req & mem_rdy_i & ~reinit;
  assign cti_end = (wb_cti_i == 3'b000) | (wb_cti_i == 3'b111);

`ifdef WB_BURST_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYC);

  logic [7:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    err   = 1'b0;
    if ((state_q != S_BURST) || ack) begin
      tmo_d = 8'd0;
    end else if (req && (tmo_q == TMO_LIM)) begin
      err   = 1'b1;
      tmo_d = 8'd0;
    end else if (req && !mem_rdy_i) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    beat_seen_d = beat_seen_q;
    load        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_INIT;
          load    = 1'b1;
        end
      end
      S_INIT: begin
        state_d = wb_cyc_i ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        state_d = wb_cyc_i ? S_BURST : S_IDLE;
      end
      S_BURST: begin
        if (!wb_cyc_i || err) begin
          state_d = S_IDLE;
        end else if (reinit && req) begin
          state_d = S_INIT;
          load    = 1'b1;
        end else if (ack && cti_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // INIT is only ever entered through a load, so that is where the line's
    // beat history restarts.
    if (load) begin
      beat_seen_d = 1'b0;
    end else if (ack) begin
      beat_seen_d = 1'b1;
    end

    adr_d = load ? wb_adr_i : adr_q;
    cti_d = load ? wb_cti_i : cti_q;
    bte_d = load ? wb_bte_i : bte_q;
    we_d  = load ? wb_we_i  : we_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_seen_q <= 1'b0;
      adr_q       <= 4'd0;
      cti_q       <= 3'd0;
      bte_q       <= 2'd0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_seen_q <= beat_seen_d;
      adr_q       <= adr_d;
      cti_q       <= cti_d;
      bte_q       <= bte_d;
      we_q        <= we_d;
    end
  end

  // Strobes are masked while reset is held so a burst interrupted by reset
  // never acknowledges in the reset cycle.
  assign wb_ack_o = ack & ~rst;
  assign inc_o    = ack & ~rst;
  assign wb_err_o = err & ~rst;
  assign init_o   = (state_q == S_INIT) & ~rst;
  assign adr_o    = adr_q;
  assign cti_o    = cti_q;
  assign bte_o    = bte_q;
  assign we_o     = we_q;

endmodule

// File: tb/tb_wb_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_burst_ctrl
//
// Directed bench for wb_burst_ctrl. A small incrementer model produces done_i
// from init_o/inc_o. Inputs change 1ns after the rising edge, outputs are
// sampled on the falling edge. Expected start addresses of every init_o pulse
// are queued in exp_q and popped when the pulse is seen.
// ---------------------------------------------------------------------------
module tb_wb_burst_ctrl;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wb_cyc_i = 1'b0;
  logic       wb_stb_i = 1'b0;
  logic       wb_we_i  = 1'b0;
  logic [3:0] wb_adr_i = 4'd0;
  logic [2:0] wb_cti_i = 3'd0;
  logic [1:0] wb_bte_i = 2'd0;
  logic       mem_rdy_i = 1'b0;
  logic       done_i;
  logic       wb_ack_o, wb_err_o, we_o, init_o, inc_o;
  logic [3:0] adr_o;
  logic [2:0] cti_o;
  logic [1:0] bte_o;

  wb_burst_ctrl #(.TIMEOUT_CYC(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_cti_i  (wb_cti_i),
    .wb_bte_i  (wb_bte_i),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .mem_rdy_i (mem_rdy_i),
    .done_i    (done_i),
    .adr_o     (adr_o),
    .cti_o     (cti_o),
    .bte_o     (bte_o),
    .we_o      (we_o),
    .init_o    (init_o),
    .inc_o     (inc_o)
  );

  // incrementer model: done sets when a linear walk steps past word 15
  logic [3:0] m_ptr = 4'd0;
  logic       m_done = 1'b0;
  assign done_i = m_done;

  always @(posedge clk) begin
    if (rst) begin
      m_ptr  <= 4'd0;
      m_done <= 1'b0;
    end else if (init_o) begin
      m_ptr  <= adr_o;
      m_done <= 1'b0;
    end else if (inc_o) begin
      case (bte_o)
        2'b01:   m_ptr <= {m_ptr[3:2], m_ptr[1:0] + 2'd1};
        2'b10:   m_ptr <= {m_ptr[3], m_ptr[2:0] + 3'd1};
        default: begin
          if (m_ptr == 4'd15) m_done <= 1'b1;
          m_ptr <= m_ptr + 4'd1;
        end
      endcase
    end
  end

  int ack_cnt = 0;
  int inc_cnt = 0;
  always @(posedge clk) begin
    ack_cnt <= ack_cnt + int'(wb_ack_o);
    inc_cnt <= inc_cnt + int'(inc_o);
  end

  // scoreboard
  logic [3:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step(input string tag, input logic ea, input logic ei, input logic ee = 1'b0);
    @(negedge clk);
    chk({tag, ".ack"}, 32'(wb_ack_o), 32'(ea));
    chk({tag, ".inc"}, 32'(inc_o), 32'(ea));
    chk({tag, ".init"}, 32'(init_o), 32'(ei));
    chk({tag, ".err"}, 32'(wb_err_o), 32'(ee));
    if (init_o) begin
      chk({tag, ".init_expected"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk({tag, ".init_adr"}, 32'(adr_o), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start(input string tag, input logic [3:0] a, input logic [2:0] c,
                       input logic [1:0] b, input logic w);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = a;
    wb_cti_i = c;
    wb_bte_i = b;
    wb_we_i  = w;
    exp_q.push_back(a);
    step({tag, ".idle"}, 1'b0, 1'b0);
    step({tag, ".init"}, 1'b0, 1'b1);
    step({tag, ".wait"}, 1'b0, 1'b0);
  endtask

  task automatic go_idle(input string tag);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    step(tag, 1'b0, 1'b0);
  endtask

  task automatic chk_regs(input string tag, input logic [3:0] a, input logic [2:0] c,
                          input logic [1:0] b, input logic w);
    chk({tag, ".adr_o"}, 32'(adr_o), 32'(a));
    chk({tag, ".cti_o"}, 32'(cti_o), 32'(c));
    chk({tag, ".bte_o"}, 32'(bte_o), 32'(b));
    chk({tag, ".we_o"}, 32'(we_o), 32'(w));
  endtask

  logic [5:0] rdy_pat;
  int a0, i0;

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 4'd0, 3'd0, 2'd0, 1'b0);
    step("reset", 1'b0, 1'b0);
    rst = 1'b0;
    step("post_reset", 1'b0, 1'b0);

    // classic single read at 5, then back-to-back request, then aborts
    mem_rdy_i = 1'b1;
    start("cls", 4'd5, 3'b000, 2'b00, 1'b0);
    step("cls.beat", 1'b1, 1'b0);
    chk_regs("cls", 4'd5, 3'b000, 2'b00, 1'b0);
    wb_adr_i = 4'd9;
    exp_q.push_back(4'd9);
    step("b2b.idle", 1'b0, 1'b0);
    step("b2b.init", 1'b0, 1'b1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    step("abort_wait", 1'b0, 1'b0);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = 4'd3;
    exp_q.push_back(4'd3);
    step("abort.idle", 1'b0, 1'b0);
    step("abort.init", 1'b0, 1'b1);
    go_idle("abort2_wait");
    go_idle("abort2.idle");

    // wrap4 write at 6, four beats
    a0 = ack_cnt;
    start("wr4", 4'd6, 3'b010, 2'b01, 1'b1);
    chk_regs("wr4", 4'd6, 3'b010, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) step("wr4.beat", 1'b1, 1'b0);
    wb_cti_i = 3'b111;
    step("wr4.last", 1'b1, 1'b0);
    go_idle("wr4.idle");
    chk("wr4.acks", 32'(ack_cnt - a0), 32'd4);

    // linear burst from 14: line exhausted after two beats, reload at 0
    start("lin", 4'd14, 3'b010, 2'b00, 1'b0);
    step("lin.b14", 1'b1, 1'b0);
    wb_adr_i = 4'd15;
    step("lin.b15", 1'b1, 1'b0);
    wb_adr_i = 4'd0;
    exp_q.push_back(4'd0);
    step("lin.reinit", 1'b0, 1'b0);
    step("lin.init", 1'b0, 1'b1);
    chk_regs("lin.reload", 4'd0, 3'b010, 2'b00, 1'b0);
    step("lin.wait", 1'b0, 1'b0);
    wb_adr_i = 4'd0;
    step("lin.b0", 1'b1, 1'b0);
    wb_adr_i = 4'd1;
    wb_cti_i = 3'b111;
    step("lin.b1", 1'b1, 1'b0);
    go_idle("lin.idle");

    // memory readiness toggling, four beats
    a0 = ack_cnt;
    i0 = inc_cnt;
    start("rdy", 4'd0, 3'b010, 2'b00, 1'b0);
    rdy_pat = 6'b111001;
    for (int i = 0; i < 6; i++) begin
      mem_rdy_i = rdy_pat[i];
      if (i == 5) wb_cti_i = 3'b111;
      step("rdy.beat", rdy_pat[i], 1'b0);
    end
    go_idle("rdy.idle");
    chk("rdy.acks", 32'(ack_cnt - a0), 32'd4);
    chk("rdy.incs", 32'(inc_cnt - i0), 32'd4);
    mem_rdy_i = 1'b1;

    // reset in the middle of a wrap8 burst
    start("rst", 4'd7, 3'b010, 2'b10, 1'b1);
    step("rst.beat", 1'b1, 1'b0);
    rst = 1'b1;
    step("rst.assert", 1'b0, 1'b0);
    rst = 1'b0;
    chk_regs("rst.cleared", 4'd0, 3'd0, 2'd0, 1'b0);
    exp_q.push_back(4'd7);
    step("rst.idle", 1'b0, 1'b0);
    step("rst.init", 1'b0, 1'b1);
    go_idle("rst.abort");
    go_idle("rst.idle2");

    // stalled burst
    start("tmo", 4'd0, 3'b010, 2'b00, 1'b0);
    mem_rdy_i = 1'b0;
`ifdef WB_BURST_TIMEOUT_EN
    for (int i = 0; i < 3; i++) step("tmo.stall", 1'b0, 1'b0, 1'b0);
    step("tmo.err", 1'b0, 1'b0, 1'b1);
    exp_q.push_back(4'd0);
    step("tmo.idle", 1'b0, 1'b0);
    step("tmo.init", 1'b0, 1'b1);
    go_idle("tmo.abort");
`else
    for (int i = 0; i < 20; i++) step("tmo.stall", 1'b0, 1'b0, 1'b0);
    mem_rdy_i = 1'b1;
    wb_cti_i = 3'b111;
    step("tmo.resume", 1'b1, 1'b0);
`endif
    go_idle("tmo.idle2");

    chk("exp_q.drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #50000;
    n_miss++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
